xor_tree_fault_monitor: RTL
===========================

Name: xor_tree_fault_monitor

Overview:
- Parametrised laser fault-injection target: a WIDTH-input XOR tree (dont_touch) fed from a registered operand, checked every cycle against an independently built golden parity.
- Three operand modes: static pins; toggle, where bit 0 is driven by an internal divided clock for photon-emission localisation; and sweep, which walks all 2^WIDTH vectors.
- Counts mismatches and latches the first faulting vector, so a laser campaign can be scored on-chip.

Parameters:
WIDTH, 6, number of XOR inputs (2..16)
CNT_W, 16, fault counter width (saturating)
DIV_W, 4, toggle divider width; bit-0 toggle period = 2^(DIV_W+1) cycles

Ports:
sysclk_n  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
a  in  WIDTH  external operand (static/toggle modes)
mode  in  2  00 static, 01 toggle, 10 sweep, 11 reserved (treated as static)
arm  in  1  level; fault counting enabled while high
clr  in  1  one-cycle pulse; clears counter, flag, captured vector, sweep state
q  out  1  registered target XOR output
fault  out  1  sticky: at least one mismatch seen since reset/clr
fault_cnt  out  CNT_W  number of mismatch cycles while armed, saturating
fault_vec  out  WIDTH  operand of the first counted mismatch
sweep_done  out  1  sticky: sweep completed one full pass

Behaviour:
- Reset (rst_n=0 at clock edge): all registers 0.
  - Outputs after reset: q=0, fault=0, fault_cnt=0, fault_vec=0, sweep_done=0.
  - Internal: divider=0, toggle bit=0, sweep counter=0, FSM=IDLE.
  - Reset wins over every other input, including mid-sweep.
- Stage 1, cycle N: op_r is registered from the source selected by mode.
  - static: op_r <= a.
  - toggle: op_r <= {a[WIDTH-1:1], tog}.
  - sweep: op_r <= sweep counter.
- Divider runs only in toggle mode. When it reaches all-ones it wraps to 0 and tog inverts. It holds its value in other modes.
- Stage 2, cycle N+1:
  - q <= ^op_r through the dont_touch target tree.
  - gold_r <= parity of op_r from a separately kept (keep/dont_touch) chain.
  - op_d <= op_r.
- Latency from a to q: 2 cycles.
- Mismatch = (q != gold_r), evaluated combinationally in cycle N+2.
- Counted mismatch = mismatch AND FSM in ARMED or SWEEP. On a counted mismatch:
  - fault_cnt increments, saturating at 2^CNT_W-1.
  - fault <= 1.
  - If fault was 0, fault_vec <= op_d; later faults do not overwrite it.
- Mismatches in IDLE or DONE are ignored.
- FSM:
  - IDLE -> ARMED when arm=1 and mode!=10.
  - IDLE -> SWEEP when arm=1 and mode=10. The sweep counter starts at 0.
  - ARMED -> IDLE when arm=0.
  - SWEEP: sweep counter increments each cycle. On the wrap from 2^WIDTH-1 to 0:
    - sweep_done <= 1;
    - FSM waits 2 more cycles to drain the pipeline, then -> DONE.
  - SWEEP -> IDLE when arm=0 or mode changes. The counter is kept; sweep_done is unchanged.
  - DONE -> IDLE when arm=0.
  - clr in any state -> IDLE.
- clr, single cycle:
  - Clears fault, fault_cnt, fault_vec, sweep_done and the sweep counter.
  - If a counted mismatch coincides with clr, clr wins: counter=0, fault=0.
  - The pipeline registers (op_r, q, gold_r) are not cleared.
- Mode change while ARMED:
  - The operand source switches at the next edge.
  - The divider state is kept.
  - No false mismatch may result; q and gold_r always derive from the same op_r.
- Saturation: once at max, fault_cnt stays there; fault stays 1.
- No combinational path from inputs to any output.

Test Plan:
- Reset and static pass-through:
  - hold rst_n=0 for 3 cycles -> all outputs 0.
  - Then mode=00, a=6'b000111 -> q=1 two cycles later.
  - a=6'b000011 -> q=0.
  - fault_cnt stays 0 throughout.
- Toggle mode, DIV_W=4, mode=01, a=0 -> q is a square wave with period 32 cycles, 50% duty; no faults counted.
- Sweep, WIDTH=6, arm=1, mode=10:
  - after 64 vectors, sweep_done=1 and the FSM reaches DONE 2 cycles later;
  - q over the sweep equals the parity of 0..63 in order; fault_cnt=0.
- Forced fault (bench forces the target output inverted for 3 cycles, with op_r=6'h2A on the first):
  - fault=1, fault_cnt=3, fault_vec=6'h2A.
  - The same forcing with arm=0 -> fault_cnt=0.
- Saturation and clr, CNT_W=4, fault forced for 20 cycles:
  - fault_cnt=15.
  - clr pulse on the same cycle as a mismatch -> fault_cnt=0, fault=0, fault_vec=0.
- Reset mid-sweep, rst_n=0 at vector 30:
  - all outputs 0, FSM IDLE.
  - Re-arming restarts the sweep at vector 0.

Source files
------------

// File: rtl/xor_tree_fault_monitor.sv
// Laser fault-injection target: registered operand feeds a protected XOR tree
// that is compared each cycle against an independently built parity chain.
module xor_tree_fault_monitor #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16,
    parameter int DIV_W = 4
) (
    input  logic             sysclk_n,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       mode,
    input  logic             arm,
    input  logic             clr,
    output logic             q,
    output logic             fault,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [WIDTH-1:0] fault_vec,
    output logic             sweep_done
);

    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_SWEEP = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [WIDTH-1:0] op_d, op_q;
    logic [WIDTH-1:0] op_dly_d, op_dly_q;
    logic             tgt_d, tgt_q;
    logic             gold_d, gold_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic             tog_d, tog_q;
    logic [WIDTH-1:0] sweep_cnt_d, sweep_cnt_q;
    logic [2:0]       state_d, state_q;
    logic             drain_d, drain_q;
    logic             fault_d, fault_q;
    logic [CNT_W-1:0] fault_cnt_d, fault_cnt_q;
    logic [WIDTH-1:0] fault_vec_d, fault_vec_q;
    logic             sweep_done_d, sweep_done_q;

    logic             sweep_run_s;
    logic             sweep_wrap_s;
    logic             count_en_s;
    logic             counted_s;

    // The target tree and the golden chain must stay physically separate so a
    // laser hit on one is visible against the other.
    (* dont_touch = "true" *) logic tree_s;
    (* keep = "true", dont_touch = "true" *) logic gold_par_s;

    assign tree_s = ^op_q;

    always_comb begin
        gold_par_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            gold_par_s = gold_par_s ^ op_q[i];
        end
    end

    always_comb begin
        div_d = div_q;
        tog_d = tog_q;
        if (mode == MODE_TOGGLE) begin
            if (div_q == {DIV_W{1'b1}}) begin
                div_d = {DIV_W{1'b0}};
                tog_d = ~tog_q;
            end else begin
                div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            div_d = div_q;
        end
    end

    always_comb begin
        case (mode)
            MODE_TOGGLE: op_d = {a[WIDTH-1:1], tog_q};
            MODE_SWEEP:  op_d = sweep_cnt_q;
            default:     op_d = a;
        endcase
        op_dly_d = op_q;
        tgt_d    = tree_s;
        gold_d   = gold_par_s;
    end

    assign sweep_run_s  = arm && (mode == MODE_SWEEP);
    assign sweep_wrap_s = (state_q == S_SWEEP) && sweep_run_s &&
                          (sweep_cnt_q == {WIDTH{1'b1}});

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = (mode == MODE_SWEEP) ? S_SWEEP : S_ARMED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (!arm) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_SWEEP: begin
                    if (!sweep_run_s) begin
                        state_d = S_IDLE;
                    end else if (sweep_wrap_s) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        state_d = S_SWEEP;
                    end
                end
                // Two extra cycles let the last vector reach the comparator.
                S_DRAIN: begin
                    if (!sweep_run_s) begin
                        state_d = S_IDLE;
                    end else if (drain_q) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (!arm) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_en_s = (state_q == S_ARMED) || (state_q == S_SWEEP) || (state_q == S_DRAIN);
        counted_s  = count_en_s && (tgt_q != gold_q);
    end

    always_comb begin
        sweep_cnt_d  = sweep_cnt_q;
        sweep_done_d = sweep_done_q;
        if (clr) begin
            sweep_cnt_d  = {WIDTH{1'b0}};
            sweep_done_d = 1'b0;
        end else if ((state_q == S_IDLE) && sweep_run_s) begin
            sweep_cnt_d = {WIDTH{1'b0}};
        end else if ((state_q == S_SWEEP) && sweep_run_s) begin
            sweep_cnt_d = sweep_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            if (sweep_wrap_s) begin
                sweep_done_d = 1'b1;
            end else begin
                sweep_done_d = sweep_done_q;
            end
        end else begin
            sweep_cnt_d = sweep_cnt_q;
        end
    end

    always_comb begin
        fault_d     = fault_q;
        fault_cnt_d = fault_cnt_q;
        fault_vec_d = fault_vec_q;
        if (clr) begin
            fault_d     = 1'b0;
            fault_cnt_d = {CNT_W{1'b0}};
            fault_vec_d = {WIDTH{1'b0}};
        end else if (counted_s) begin
            fault_d = 1'b1;
            if (fault_cnt_q != {CNT_W{1'b1}}) begin
                fault_cnt_d = fault_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                fault_cnt_d = fault_cnt_q;
            end
            if (!fault_q) begin
                fault_vec_d = op_dly_q;
            end else begin
                fault_vec_d = fault_vec_q;
            end
        end else begin
            fault_d = fault_q;
        end
    end

    always_ff @(posedge sysclk_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge sysclk_n) begin
        if (!rst_n) begin
            op_q         <= {WIDTH{1'b0}};
            op_dly_q     <= {WIDTH{1'b0}};
            tgt_q        <= 1'b0;
            gold_q       <= 1'b0;
            div_q        <= {DIV_W{1'b0}};
            tog_q        <= 1'b0;
            sweep_cnt_q  <= {WIDTH{1'b0}};
            sweep_done_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_cnt_q  <= {CNT_W{1'b0}};
            fault_vec_q  <= {WIDTH{1'b0}};
        end else begin
            op_q         <= op_d;
            op_dly_q     <= op_dly_d;
            tgt_q        <= tgt_d;
            gold_q       <= gold_d;
            div_q        <= div_d;
            tog_q        <= tog_d;
            sweep_cnt_q  <= sweep_cnt_d;
            sweep_done_q <= sweep_done_d;
            fault_q      <= fault_d;
            fault_cnt_q  <= fault_cnt_d;
            fault_vec_q  <= fault_vec_d;
        end
    end

    assign q          = tgt_q;
    assign fault      = fault_q;
    assign fault_cnt  = fault_cnt_q;
    assign fault_vec  = fault_vec_q;
    assign sweep_done = sweep_done_q;

endmodule
